// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
//
// Sprite-attribute (OAM) DMA engine.  A CPU write of a page number to
// TriggerAddr copies Length bytes from {page, 8'h00} upward into OAM starting
// at OamBase, one byte every two cycles (READ then WRITE), while the CPU is
// stalled through cpu_clk_enable.
//
// Ports
//   clk_1           in   CPU-domain clock, all state on its rising edge
//   rst_n           in   asynchronous active-low reset
//   cpu_address     in   [15:0] CPU bus address
//   cpu_data_in     in   [7:0]  CPU write data
//   cpu_wen_n       in   CPU write strobe, active low
//   mem_data_in     in   [7:0]  bus read data for bus_address, same cycle
//   cpu_clk_enable  out  1 = CPU runs, 0 = CPU stalled
//   bus_owner       out  1 = DMA drives the bus, 0 = CPU passthrough
//   bus_address     out  [15:0] bus address (DMA or CPU passthrough)
//   bus_data        out  [7:0]  bus write data (DMA or CPU passthrough)
//   bus_wen_n       out  bus write strobe, active low
//   busy            out  high from trigger acceptance until DONE exits
//   done            out  one-cycle pulse in the cycle after the last write
//   fsm_state       out  [2:0] current FSM state (IDLE=0 HALT=1 READ=2
//                        WRITE=3 DONE=4), for observation only
//
// Bus handshake: there is no valid/ready pair.  Ownership is decided purely
// by the registered bus_owner flag; when it is 0 the CPU signals pass
// straight through, when it is 1 the DMA address/data/strobe are driven and
// the CPU is guaranteed stalled (cpu_clk_enable=0).  Reads complete in the
// cycle they are issued (mem_data_in is sampled at the end of READ).
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] TriggerAddr = 16'h7010,
    parameter logic [15:0] OamBase     = 16'h4800,
    parameter int          Length      = 256
) (
    input  logic        clk_1,
    input  logic        rst_n,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_wen_n,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_clk_enable,
    output logic        bus_owner,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_data,
    output logic        bus_wen_n,
    output logic        busy,
    output logic        done,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // idx is 8 bits, so Length=256 finishes at idx=255 without a wrap cycle.
    localparam logic [7:0] LastIdx = 8'(Length - 1);

    state_t      state;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  byte_q;
    logic        dma_wen_n;   // DMA strobe, low only while in WRITE
    logic        wen_block;   // masks the CPU strobe in HALT and DONE
    logic        trigger;
    logic [15:0] write_addr;

    // The trigger only steers the next state; no output depends on it
    // combinationally, so cpu_* never reaches cpu_clk_enable in one cycle.
    assign trigger    = (cpu_wen_n == 1'b0) && (cpu_address == TriggerAddr);
    assign write_addr = OamBase + {8'h00, idx};
    assign fsm_state  = state;

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            page           <= 8'h00;
            idx            <= 8'h00;
            byte_q         <= 8'h00;
            cpu_clk_enable <= 1'b1;
            bus_owner      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            dma_wen_n      <= 1'b1;
            wen_block      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The triggering write itself passes through this cycle;
                    // the stall starts on the next one.
                    if (trigger) begin
                        page           <= cpu_data_in;
                        idx            <= 8'h00;
                        state          <= S_HALT;
                        cpu_clk_enable <= 1'b0;
                        busy           <= 1'b1;
                        wen_block      <= 1'b1;
                    end
                end
                S_HALT: begin
                    state     <= S_READ;
                    bus_owner <= 1'b1;
                    wen_block <= 1'b0;
                end
                S_READ: begin
                    byte_q    <= mem_data_in;
                    state     <= S_WRITE;
                    dma_wen_n <= 1'b0;
                end
                S_WRITE: begin
                    dma_wen_n <= 1'b1;
                    if (idx == LastIdx) begin
                        state          <= S_DONE;
                        bus_owner      <= 1'b0;
                        cpu_clk_enable <= 1'b1;
                        done           <= 1'b1;
                        wen_block      <= 1'b1;
                    end else begin
                        idx   <= idx + 8'h01;
                        state <= S_READ;
                    end
                end
                S_DONE: begin
                    // A trigger seen here is dropped, not remembered.
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    wen_block <= 1'b0;
                end
                default: begin
                    state          <= S_IDLE;
                    cpu_clk_enable <= 1'b1;
                    bus_owner      <= 1'b0;
                    busy           <= 1'b0;
                    done           <= 1'b0;
                    dma_wen_n      <= 1'b1;
                    wen_block      <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux.  In HALT and DONE the bus is not owned, but the CPU strobe is
    // still masked so no write can reach the bus in those cycles.
    always_comb begin
        bus_address = cpu_address;
        bus_data    = cpu_data_in;
        bus_wen_n   = cpu_wen_n | wen_block;
        if (bus_owner) begin
            bus_address = (state == S_WRITE) ? write_addr : {page, idx};
            bus_data    = byte_q;
            bus_wen_n   = dma_wen_n;
        end
    end

endmodule
